switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Per-router switch allocator that sits directly downstream of the router input ports.
- Consumes each input VC's one-hot destination request, empty flag and head-flit type, plus downstream on/off backpressure.
- Produces the per-VC dequeue grant (sa_grant) back to the input ports and the crossbar select/valid for every output port.
- Two-stage separable round-robin allocator with wormhole locking: an output port stays bound to one input VC from head to tail.

Parameters:
- PORT_NUM, 5: router ports (local + 4 mesh directions).
- PORT_NUM_W, $clog2(PORT_NUM): input-port index width.
- VC_PER_PORT, 2: virtual channels per port.
- VC_W, $clog2(VC_PER_PORT) (min 1): VC index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ip_dest_port  in  PORT_NUM x VC_PER_PORT x PORT_NUM  one-hot destination of head-of-FIFO flit per input VC; all-zero = no packet.
- ip_empty  in  PORT_NUM x VC_PER_PORT  input VC flit FIFO empty.
- ip_is_tail  in  PORT_NUM x VC_PER_PORT  head-of-FIFO flit type is TAIL or HT.
- on_off_in  in  PORT_NUM x VC_PER_PORT  downstream VC almost-full per output port/VC; 1 = stop.
- sa_grant  out  PORT_NUM x VC_PER_PORT  dequeue strobe to input VC FIFO.
- sa_valid  out  PORT_NUM  output port transfers a flit this cycle (crossbar write enable).
- sa_port_sel  out  PORT_NUM x PORT_NUM_W  winning input port per output.
- sa_vc_sel  out  PORT_NUM x VC_W  winning VC per output; flit leaves on the same VC index.

Behaviour:
- Grants/selects are combinational from current inputs and registered state, giving zero-cycle latency so sa_grant dequeues in the same cycle.
- State elements:
  - rr_in[p] (VC_W): per-input-port VC pointer.
  - rr_out[d] (PORT_NUM_W): per-output input-port pointer.
  - lock_vld[d], lock_port[d], lock_vc[d]: per-output wormhole owner.
- Reset (reset=0, async): all pointers 0, lock_vld all 0. sa_grant, sa_valid, sa_port_sel and sa_vc_sel are forced to 0 while reset is low.
- Eligibility of input VC (p,v) toward d, where d = onehot index of ip_dest_port[p][v]. All must hold:
  - ~ip_empty[p][v]
  - ip_dest_port[p][v] != 0
  - on_off_in[d][v] == 0
  - (~lock_vld[d] OR (lock_port[d]==p AND lock_vc[d]==v))
- Stage 1 (per input p): among eligible VCs, pick the first at or after rr_in[p] in circular order. At most one request per input port.
- Stage 2 (per output d):
  - If lock_vld[d]: only the owner may win, if it is the stage-1 winner of its port.
  - Else: among inputs whose stage-1 winner targets d, pick the first at or after rr_out[d] circularly.
- On win:
  - sa_grant[p][v]=1, sa_valid[d]=1, sa_port_sel[d]=p, sa_vc_sel[d]=v.
  - Non-winning selects are 0.
  - At most one grant per input port and per output port per cycle.
- Clocked updates on each win:
  - rr_in[p] <= v+1 mod VC_PER_PORT.
  - rr_out[d] <= p+1 mod PORT_NUM (only when unlocked at win).
  - If ~ip_is_tail: lock_vld[d]<=1, owner<=(p,v).
  - If ip_is_tail: lock_vld[d]<=0 (covers HT single-flit packets, which never lock).
- Pointers do not move without a grant.
- Backpressure mid-packet: an owner blocked by on_off_in keeps the lock; no other input may use d until the tail is granted.
- Empty owner mid-packet (body not yet arrived): lock held, no grant.
- Pointer wrap: VC_PER_PORT-1 -> 0 and PORT_NUM-1 -> 0.
- Reset mid-packet clears locks immediately. Input ports are reset together, so no orphan flits remain.
- A malformed non-one-hot ip_dest_port is a protocol error and is flagged by a simulation assertion. Assertions also check: grant only when ~ip_empty, and sa_grant one-hot per port.

Test Plan:
- Reset: hold reset=0 with all VCs non-empty -> sa_grant=0, sa_valid=0. Release -> pointers 0, first grant goes to port0 VC0 when it requests.
- Output contention: ports 1 and 3 VC0 HT flits to port 2 for 4 cycles -> grants alternate 1,3,1,3; sa_port_sel[2] follows; sa_vc_sel[2]=0.
- Wormhole lock: port1 VC0 sends HEADER, BODY, TAIL to port4 while port2 VC1 requests port4 -> port2 is granted only in the cycle after the TAIL grant.
- Backpressure: on_off_in[4][0]=1 mid-packet for 3 cycles -> no grant to owner, port2 VC1 still blocked; resumes on release.
- Stage-1 VC fairness: port0 VC0->port1 and VC1->port3, both free -> the grant alternates VC0, VC1 across cycles; never both in one cycle.
- Reset during a locked packet: after the release, an unrelated input gets the output immediately.

Source files
------------

// File: rtl/switch_allocator.sv
// Two-stage separable round-robin switch allocator with per-output wormhole locking.
// Grants are combinational from current requests and registered pointers/locks.
module switch_allocator #(
    parameter int PORT_NUM    = 5,
    parameter int PORT_NUM_W  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
    parameter int VC_PER_PORT = 2,
    parameter int VC_W        = (VC_PER_PORT > 1) ? $clog2(VC_PER_PORT) : 1
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [PORT_NUM-1:0][VC_PER_PORT-1:0][PORT_NUM-1:0] ip_dest_port,
    input  logic [PORT_NUM-1:0][VC_PER_PORT-1:0]             ip_empty,
    input  logic [PORT_NUM-1:0][VC_PER_PORT-1:0]             ip_is_tail,
    input  logic [PORT_NUM-1:0][VC_PER_PORT-1:0]             on_off_in,
    output logic [PORT_NUM-1:0][VC_PER_PORT-1:0]             sa_grant,
    output logic [PORT_NUM-1:0]                              sa_valid,
    output logic [PORT_NUM-1:0][PORT_NUM_W-1:0]              sa_port_sel,
    output logic [PORT_NUM-1:0][VC_W-1:0]                    sa_vc_sel
);

    function automatic logic [PORT_NUM_W-1:0] oh_to_idx(input logic [PORT_NUM-1:0] oh);
        logic [PORT_NUM_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (oh[i]) idx = idx | PORT_NUM_W'(i);
        end
        return idx;
    endfunction

    logic [PORT_NUM-1:0][VC_W-1:0]       rr_in_q, rr_in_d;
    logic [PORT_NUM-1:0][PORT_NUM_W-1:0] rr_out_q, rr_out_d;
    logic [PORT_NUM-1:0]                 lock_vld_q, lock_vld_d;
    logic [PORT_NUM-1:0][PORT_NUM_W-1:0] lock_port_q, lock_port_d;
    logic [PORT_NUM-1:0][VC_W-1:0]       lock_vc_q, lock_vc_d;

    logic [PORT_NUM-1:0][VC_PER_PORT-1:0][PORT_NUM_W-1:0] dst;
    logic [PORT_NUM-1:0][VC_PER_PORT-1:0]                 elig;
    logic [PORT_NUM-1:0]                 s1_vld;
    logic [PORT_NUM-1:0][VC_W-1:0]       s1_vc;
    logic [PORT_NUM-1:0][PORT_NUM_W-1:0] s1_dst;
    logic [PORT_NUM-1:0]                 win;
    logic [PORT_NUM-1:0][PORT_NUM_W-1:0] win_port;
    logic [PORT_NUM-1:0][VC_W-1:0]       win_vc;
    logic [PORT_NUM-1:0][VC_PER_PORT-1:0] grant;

    // A VC toward a locked output is eligible only if it is that output's owner.
    always_comb begin
        dst  = '0;
        elig = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_PER_PORT; v++) begin
                dst[p][v]  = oh_to_idx(ip_dest_port[p][v]);
                elig[p][v] = !ip_empty[p][v] && (ip_dest_port[p][v] != '0) &&
                             !on_off_in[dst[p][v]][v] &&
                             (!lock_vld_q[dst[p][v]] ||
                              (lock_port_q[dst[p][v]] == PORT_NUM_W'(p) &&
                               lock_vc_q[dst[p][v]] == VC_W'(v)));
            end
        end
    end

    always_comb begin
        logic [VC_W-1:0] vi;
        vi     = '0;
        s1_vld = '0;
        s1_vc  = '0;
        s1_dst = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int k = 0; k < VC_PER_PORT; k++) begin
                vi = VC_W'((int'(rr_in_q[p]) + k) % VC_PER_PORT);
                if (!s1_vld[p] && elig[p][vi]) begin
                    s1_vld[p] = 1'b1;
                    s1_vc[p]  = vi;
                    s1_dst[p] = dst[p][vi];
                end
            end
        end
    end

    always_comb begin
        logic [PORT_NUM_W-1:0] pi;
        pi       = '0;
        win      = '0;
        win_port = '0;
        win_vc   = '0;
        for (int d = 0; d < PORT_NUM; d++) begin
            if (lock_vld_q[d]) begin
                pi = lock_port_q[d];
                if (s1_vld[pi] && s1_vc[pi] == lock_vc_q[d] && s1_dst[pi] == PORT_NUM_W'(d)) begin
                    win[d]      = 1'b1;
                    win_port[d] = pi;
                    win_vc[d]   = lock_vc_q[d];
                end
            end else begin
                for (int k = 0; k < PORT_NUM; k++) begin
                    pi = PORT_NUM_W'((int'(rr_out_q[d]) + k) % PORT_NUM);
                    if (!win[d] && s1_vld[pi] && s1_dst[pi] == PORT_NUM_W'(d)) begin
                        win[d]      = 1'b1;
                        win_port[d] = pi;
                        win_vc[d]   = s1_vc[pi];
                    end
                end
            end
        end
    end

    // Each input has a single stage-1 winner, so no two outputs can grant the same VC.
    always_comb begin
        grant = '0;
        for (int d = 0; d < PORT_NUM; d++) begin
            if (win[d]) grant[win_port[d]][win_vc[d]] = 1'b1;
        end
    end

    always_comb begin
        sa_grant    = '0;
        sa_valid    = '0;
        sa_port_sel = '0;
        sa_vc_sel   = '0;
        if (reset) begin
            sa_grant    = grant;
            sa_valid    = win;
            sa_port_sel = win_port;
            sa_vc_sel   = win_vc;
        end
    end

    always_comb begin
        logic [PORT_NUM_W-1:0] p;
        logic [VC_W-1:0]       v;
        p           = '0;
        v           = '0;
        rr_in_d     = rr_in_q;
        rr_out_d    = rr_out_q;
        lock_vld_d  = lock_vld_q;
        lock_port_d = lock_port_q;
        lock_vc_d   = lock_vc_q;
        for (int d = 0; d < PORT_NUM; d++) begin
            if (win[d]) begin
                p          = win_port[d];
                v          = win_vc[d];
                rr_in_d[p] = VC_W'((int'(v) + 1) % VC_PER_PORT);
                if (!lock_vld_q[d]) rr_out_d[d] = PORT_NUM_W'((int'(p) + 1) % PORT_NUM);
                if (ip_is_tail[p][v]) begin
                    lock_vld_d[d] = 1'b0;
                end else begin
                    lock_vld_d[d]  = 1'b1;
                    lock_port_d[d] = p;
                    lock_vc_d[d]   = v;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_in_q     <= '0;
            rr_out_q    <= '0;
            lock_vld_q  <= '0;
            lock_port_q <= '0;
            lock_vc_q   <= '0;
        end else begin
            rr_in_q     <= rr_in_d;
            rr_out_q    <= rr_out_d;
            lock_vld_q  <= lock_vld_d;
            lock_port_q <= lock_port_d;
            lock_vc_q   <= lock_vc_d;
        end
    end

    for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_chk_port
        a_grant_onehot: assert property (@(posedge clk) disable iff (!reset)
            $onehot0(sa_grant[gp]));
        for (genvar gv = 0; gv < VC_PER_PORT; gv++) begin : g_chk_vc
            a_dest_onehot: assert property (@(posedge clk) disable iff (!reset)
                !ip_empty[gp][gv] |-> $onehot0(ip_dest_port[gp][gv]));
            a_grant_nonempty: assert property (@(posedge clk) disable iff (!reset)
                sa_grant[gp][gv] |-> !ip_empty[gp][gv]);
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed scoreboard bench for switch_allocator: hand-derived expected
// grants/selects are queued as stimulus is applied and checked at the falling edge.
module tb_switch_allocator;

    localparam int P  = 5;
    localparam int PW = 3;
    localparam int V  = 2;
    localparam int VW = 1;

    logic clk = 1'b0;
    logic reset;
    logic [P-1:0][V-1:0][P-1:0] ip_dest_port;
    logic [P-1:0][V-1:0]        ip_empty;
    logic [P-1:0][V-1:0]        ip_is_tail;
    logic [P-1:0][V-1:0]        on_off_in;
    logic [P-1:0][V-1:0]        sa_grant;
    logic [P-1:0]               sa_valid;
    logic [P-1:0][PW-1:0]       sa_port_sel;
    logic [P-1:0][VW-1:0]       sa_vc_sel;

    typedef struct {
        string        tag;
        logic [P*V-1:0]  grant;
        logic [P-1:0]    valid;
        logic [P*PW-1:0] psel;
        logic [P*VW-1:0] vsel;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    switch_allocator #(.PORT_NUM(P), .VC_PER_PORT(V)) dut (
        .clk          (clk),
        .reset        (reset),
        .ip_dest_port (ip_dest_port),
        .ip_empty     (ip_empty),
        .ip_is_tail   (ip_is_tail),
        .on_off_in    (on_off_in),
        .sa_grant     (sa_grant),
        .sa_valid     (sa_valid),
        .sa_port_sel  (sa_port_sel),
        .sa_vc_sel    (sa_vc_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t none(input string tag);
        exp_t e;
        e.tag   = tag;
        e.grant = '0;
        e.valid = '0;
        e.psel  = '0;
        e.vsel  = '0;
        return e;
    endfunction

    function automatic exp_t win(input exp_t ei, input int p, input int v, input int d);
        exp_t e;
        e = ei;
        e.grant[p*V+v]    = 1'b1;
        e.valid[d]        = 1'b1;
        e.psel[d*PW +: PW] = PW'(p);
        e.vsel[d*VW +: VW] = VW'(v);
        return e;
    endfunction

    task automatic clr_inputs();
        ip_empty     = '1;
        ip_dest_port = '0;
        ip_is_tail   = '0;
        on_off_in    = '0;
    endtask

    task automatic set_vc(input int p, input int v, input int d, input logic tail);
        ip_empty[p][v]        = 1'b0;
        ip_dest_port[p][v]    = '0;
        ip_dest_port[p][v][d] = 1'b1;
        ip_is_tail[p][v]      = tail;
    endtask

    // Entered just after a rising edge; inputs for this cycle are already applied.
    task automatic step(input exp_t e);
        exp_t o;
        exp_q.push_back(e);
        @(negedge clk);
        o = exp_q.pop_front();
        check_eq({o.tag, ".grant"}, 32'(sa_grant), 32'(o.grant));
        check_eq({o.tag, ".valid"}, 32'(sa_valid), 32'(o.valid));
        check_eq({o.tag, ".port_sel"}, 32'(sa_port_sel), 32'(o.psel));
        check_eq({o.tag, ".vc_sel"}, 32'(sa_vc_sel), 32'(o.vsel));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clr_inputs();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        clr_inputs();
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // reset holds all outputs low even with every VC requesting
        for (int p = 0; p < P; p++)
            for (int v = 0; v < V; v++)
                set_vc(p, v, (p + 1) % P, 1'b1);
        step(none("rst_hold"));
        clr_inputs();
        set_vc(0, 0, 2, 1'b1);
        set_vc(0, 1, 2, 1'b1);
        set_vc(1, 0, 2, 1'b1);
        set_vc(1, 1, 2, 1'b1);
        step(none("rst_hold2"));
        reset = 1'b1;
        step(win(none("rst_first"), 0, 0, 2));
        step(win(none("rr1"), 1, 0, 2));
        step(win(none("rr2"), 0, 1, 2));
        step(win(none("rr3"), 1, 1, 2));

        // output contention between ports 1 and 3
        do_reset();
        set_vc(1, 0, 2, 1'b1);
        set_vc(3, 0, 2, 1'b1);
        step(win(none("cont0"), 1, 0, 2));
        step(win(none("cont1"), 3, 0, 2));
        step(win(none("cont2"), 1, 0, 2));
        step(win(none("cont3"), 3, 0, 2));

        // wormhole lock, empty owner and backpressure
        do_reset();
        set_vc(1, 0, 4, 1'b0);
        set_vc(2, 1, 4, 1'b1);
        step(win(none("wh_head"), 1, 0, 4));
        step(win(none("wh_body"), 1, 0, 4));
        ip_empty[1][0] = 1'b1;
        step(none("wh_empty"));
        ip_empty[1][0] = 1'b0;
        on_off_in[4][0] = 1'b1;
        repeat (3) step(none("bp_stall"));
        on_off_in[4][0] = 1'b0;
        step(win(none("bp_resume"), 1, 0, 4));
        ip_is_tail[1][0] = 1'b1;
        step(win(none("wh_tail"), 1, 0, 4));
        ip_empty[1][0]     = 1'b1;
        ip_dest_port[1][0] = '0;
        step(win(none("wh_next"), 2, 1, 4));

        // stage-1 VC fairness within port 0
        do_reset();
        set_vc(0, 0, 1, 1'b1);
        set_vc(0, 1, 3, 1'b1);
        step(win(none("vcf0"), 0, 0, 1));
        step(win(none("vcf1"), 0, 1, 3));
        step(win(none("vcf2"), 0, 0, 1));
        step(win(none("vcf3"), 0, 1, 3));

        // reset while an output is locked
        do_reset();
        set_vc(1, 0, 4, 1'b0);
        step(win(none("lk_head"), 1, 0, 4));
        set_vc(3, 0, 4, 1'b1);
        step(win(none("lk_hold"), 1, 0, 4));
        reset = 1'b0;
        step(none("lk_rst"));
        reset = 1'b1;
        ip_empty[1][0]     = 1'b1;
        ip_dest_port[1][0] = '0;
        step(win(none("lk_after"), 3, 0, 4));

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
